tag_array_assoc: RTL and testbench

Set-associative tag store for the data cache. It holds, per set and way, a tag, a valid bit and an optional dirty bit, plus per-set tree pseudo-LRU state. It answers a registered hit/victim lookup one cycle after request, accepts fill/update writes from the cache controller, and runs a self-timed flush sequencer that invalidates every set. It sits between the cache controller FSM and the data RAM way-select logic.

---
 rtl/tag_array_assoc.sv | 199 +++++++++++++++++++
 tb/tb_tag_array_assoc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_assoc.sv
// Set-associative tag store with tree PLRU, registered hit/victim lookup and a self-timed flush.
// Define TAG_DIRTY_EN to implement per-way dirty bits; otherwise rsp_vic_dirty is tied low.
module tag_array_assoc #(
   parameter int TAG_W   = 20,
   parameter int INDEX_W = 6,
   parameter int WAYS    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     lk_valid,
   input  logic [INDEX_W-1:0]       lk_index,
   input  logic [TAG_W-1:0]         lk_tag,
   input  logic                     lk_write,
   output logic                     rsp_valid,
   output logic                     rsp_hit,
   output logic [$clog2(WAYS)-1:0]  rsp_way,
   output logic                     rsp_vic_valid,
   output logic                     rsp_vic_dirty,
   output logic [TAG_W-1:0]         rsp_vic_tag,
   input  logic                     upd_en,
   input  logic [INDEX_W-1:0]       upd_index,
   input  logic [$clog2(WAYS)-1:0]  upd_way,
   input  logic [TAG_W-1:0]         upd_tag,
   input  logic                     upd_dirty,
   input  logic                     flush_req,
   output logic                     busy,
   output logic                     flush_done
);

   localparam int WAY_W  = $clog2(WAYS);
   localparam int SETS   = 1 << INDEX_W;
   localparam int PLRU_W = (WAYS == 4) ? 3 : 1;

   typedef enum logic [1:0] {IDLE, FLUSH, DONE} flushStateT;

   flushStateT state, nextState;
   logic [INDEX_W-1:0] flushCnt;

   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tagMem;
   logic [SETS-1:0][WAYS-1:0]            validMem;
   logic [SETS-1:0][PLRU_W-1:0]          plruMem;
`ifdef TAG_DIRTY_EN
   logic [SETS-1:0][WAYS-1:0]            dirtyMem;
`endif

   logic [WAYS-1:0]   lkValidSet;
   logic              lkHit;
   logic              lkTouch;
   logic              lkVicDirty;
   logic [WAY_W-1:0]  hitWay;
   logic [WAY_W-1:0]  invWay;
   logic [WAY_W-1:0]  victimWay;
   logic [PLRU_W-1:0] lkPlruNext;
   logic [PLRU_W-1:0] updPlruBase;
   logic [PLRU_W-1:0] updPlruNext;

   // PLRU bits are widened to the 4-way layout internally so one body serves both associativities
   function automatic logic [WAY_W-1:0] plruVictim(input logic [PLRU_W-1:0] p);
      logic [2:0] b;
      logic [1:0] v;
      b = 3'(p);
      if (WAYS == 4)
         v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
      else
         v = {1'b0, b[0]};
      return WAY_W'(v);
   endfunction

   function automatic logic [PLRU_W-1:0] plruTouch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0] way);
      logic [2:0] b;
      logic [1:0] w;
      b = 3'(p);
      w = 2'(way);
      if (WAYS == 4) begin
         case (w)
            2'd0:    begin b[0] = 1'b1; b[1] = 1'b1; end
            2'd1:    begin b[0] = 1'b1; b[1] = 1'b0; end
            2'd2:    begin b[0] = 1'b0; b[2] = 1'b1; end
            default: begin b[0] = 1'b0; b[2] = 1'b0; end
         endcase
      end else begin
         b[0] = ~w[0];
      end
      return PLRU_W'(b);
   endfunction

   // Descending scan so the lowest matching / lowest invalid way wins
   always_comb begin
      lkValidSet = validMem[lk_index];
      lkHit      = 1'b0;
      hitWay     = '0;
      invWay     = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (lkValidSet[w] && (tagMem[lk_index][w] == lk_tag)) begin
            lkHit  = 1'b1;
            hitWay = WAY_W'(w);
         end
         if (!lkValidSet[w])
            invWay = WAY_W'(w);
      end
      victimWay = (&lkValidSet) ? plruVictim(plruMem[lk_index]) : invWay;
   end

`ifdef TAG_DIRTY_EN
   assign lkVicDirty = dirtyMem[lk_index][victimWay];
`else
   logic unusedDirtyInputs;
   assign unusedDirtyInputs = lk_write | upd_dirty;
   assign lkVicDirty        = 1'b0;
`endif

   // A same-set fill touches PLRU after the lookup's touch
   assign lkTouch     = lk_valid && lkHit && !busy;
   assign lkPlruNext  = plruTouch(plruMem[lk_index], hitWay);
   assign updPlruBase = (lkTouch && (lk_index == upd_index)) ? lkPlruNext : plruMem[upd_index];
   assign updPlruNext = plruTouch(updPlruBase, upd_way);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         flushCnt <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE)
            flushCnt <= '0;
         else if (state == FLUSH)
            flushCnt <= flushCnt + 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (flush_req) nextState = FLUSH;
         FLUSH:   if (&flushCnt) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign flush_done = (state == DONE);

   // Fill writes are placed after lookup writes so the fill wins on a shared way
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tagMem   <= '0;
         validMem <= '0;
         plruMem  <= '0;
`ifdef TAG_DIRTY_EN
         dirtyMem <= '0;
`endif
      end else if (state == FLUSH) begin
         validMem[flushCnt] <= '0;
         plruMem[flushCnt]  <= '0;
`ifdef TAG_DIRTY_EN
         dirtyMem[flushCnt] <= '0;
`endif
      end else if (!busy) begin
         if (lkTouch) begin
            plruMem[lk_index] <= lkPlruNext;
`ifdef TAG_DIRTY_EN
            if (lk_write)
               dirtyMem[lk_index][hitWay] <= 1'b1;
`endif
         end
         if (upd_en) begin
            tagMem[upd_index][upd_way]   <= upd_tag;
            validMem[upd_index][upd_way] <= 1'b1;
            plruMem[upd_index]           <= updPlruNext;
`ifdef TAG_DIRTY_EN
            dirtyMem[upd_index][upd_way] <= upd_dirty;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid     <= 1'b0;
         rsp_hit       <= 1'b0;
         rsp_way       <= '0;
         rsp_vic_valid <= 1'b0;
         rsp_vic_dirty <= 1'b0;
         rsp_vic_tag   <= '0;
      end else begin
         rsp_valid <= lk_valid;
         if (lk_valid) begin
            rsp_hit       <= lkHit && !busy;
            rsp_way       <= (lkHit && !busy) ? hitWay : victimWay;
            rsp_vic_valid <= lkValidSet[victimWay] && !busy;
            rsp_vic_dirty <= lkVicDirty && !busy;
            rsp_vic_tag   <= tagMem[lk_index][victimWay];
         end
      end
   end

endmodule

// File: tb/tb_tag_array_assoc.sv
// Scoreboard bench for tag_array_assoc: stimulus pushes expected responses, a monitor pops and compares.
module tb_tag_array_assoc;

   localparam int TAG_W   = 20;
   localparam int INDEX_W = 6;
   localparam int WAYS    = 4;
`ifdef TAG_DIRTY_EN
   localparam logic DIRTY_ON = 1'b1;
`else
   localparam logic DIRTY_ON = 1'b0;
`endif

   typedef struct {
      string      name;
      logic       hit;
      logic [1:0] way;
      logic       checkWay;
      logic       vicValid;
      logic       checkVic;
      logic       vicDirty;
      logic [19:0] vicTag;
   } expT;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               lk_valid, lk_write, upd_en, upd_dirty, flush_req;
   logic [INDEX_W-1:0] lk_index, upd_index;
   logic [TAG_W-1:0]   lk_tag, upd_tag, rsp_vic_tag;
   logic [1:0]         upd_way, rsp_way;
   logic               rsp_valid, rsp_hit, rsp_vic_valid, rsp_vic_dirty, busy, flush_done;

   int  checks = 0;
   int  errors = 0;
   expT expQ[$];

   always #5 clk = ~clk;

   tag_array_assoc #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
      .clk(clk), .rst_n(rst_n),
      .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_write(lk_write),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
      .rsp_vic_valid(rsp_vic_valid), .rsp_vic_dirty(rsp_vic_dirty), .rsp_vic_tag(rsp_vic_tag),
      .upd_en(upd_en), .upd_index(upd_index), .upd_way(upd_way), .upd_tag(upd_tag),
      .upd_dirty(upd_dirty), .flush_req(flush_req), .busy(busy), .flush_done(flush_done)
   );

   function automatic void checkOutput(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endfunction

   function automatic expT mkExp(string nm, logic h, logic [1:0] wy, logic cw,
                                 logic vv, logic cv, logic vd, logic [19:0] vt);
      expT e;
      e.name = nm; e.hit = h; e.way = wy; e.checkWay = cw;
      e.vicValid = vv; e.checkVic = cv; e.vicDirty = vd; e.vicTag = vt;
      return e;
   endfunction

   // Every response strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      expT e;
      if (rst_n && rsp_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response");
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_hit"}, 32'(rsp_hit), 32'(e.hit));
            checkOutput({e.name, "_vicValid"}, 32'(rsp_vic_valid), 32'(e.vicValid));
            if (e.checkWay)
               checkOutput({e.name, "_way"}, 32'(rsp_way), 32'(e.way));
            if (e.checkVic) begin
               checkOutput({e.name, "_vicDirty"}, 32'(rsp_vic_dirty), 32'(e.vicDirty));
               checkOutput({e.name, "_vicTag"}, 32'(rsp_vic_tag), 32'(e.vicTag));
            end
         end
      end
   end

   task automatic applyStimulus(input logic lv, input logic [5:0] li, input logic [19:0] lt,
                                input logic lw, input logic ue, input logic [5:0] ui,
                                input logic [1:0] uw, input logic [19:0] ut, input logic ud,
                                input logic fr);
      lk_valid = lv; lk_index = li; lk_tag = lt; lk_write = lw;
      upd_en = ue; upd_index = ui; upd_way = uw; upd_tag = ut; upd_dirty = ud;
      flush_req = fr;
      @(posedge clk);
      #1;
      lk_valid = 1'b0; lk_write = 1'b0; upd_en = 1'b0; flush_req = 1'b0;
   endtask

   task automatic lookup(input logic [5:0] idx, input logic [19:0] tag, input logic wr, input expT e);
      expQ.push_back(e);
      applyStimulus(1'b1, idx, tag, wr, 1'b0, 6'd0, 2'd0, 20'd0, 1'b0, 1'b0);
   endtask

   task automatic fill(input logic [5:0] idx, input logic [1:0] way, input logic [19:0] tag, input logic d);
      applyStimulus(1'b0, 6'd0, 20'd0, 1'b0, 1'b1, idx, way, tag, d, 1'b0);
   endtask

   initial begin
      int busyCycles;
      int doneCount;
      rst_n = 1'b0;
      lk_valid = 0; lk_index = 0; lk_tag = 0; lk_write = 0;
      upd_en = 0; upd_index = 0; upd_way = 0; upd_tag = 0; upd_dirty = 0; flush_req = 0;
      #12;
      checkOutput("reset_rspValid", 32'(rsp_valid), 0);
      checkOutput("reset_rspHit", 32'(rsp_hit), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_flushDone", 32'(flush_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      lookup(6'd5, 20'h123, 1'b0, mkExp("coldMiss", 0, 2'd0, 1, 0, 1, 0, 20'h0));

      for (int w = 0; w < 4; w++)
         fill(6'd5, 2'(w), 20'hA + 20'(w), 1'b0);
      lookup(6'd5, 20'hB, 1'b0, mkExp("hitB", 1, 2'd1, 1, 1, 1, 0, 20'hA));
      lookup(6'd5, 20'hF, 1'b0, mkExp("missF", 0, 2'd2, 1, 1, 1, 0, 20'hC));

      // Store hit on way 0, then touch ways 1..3 so way 0 becomes the dirty victim
      lookup(6'd5, 20'hA, 1'b1, mkExp("storeA", 1, 2'd0, 1, 1, 1, 0, 20'hC));
      lookup(6'd5, 20'hB, 1'b0, mkExp("touchB", 1, 2'd1, 1, 1, 1, 0, 20'hC));
      lookup(6'd5, 20'hC, 1'b0, mkExp("touchC", 1, 2'd2, 1, 1, 1, 0, 20'hC));
      lookup(6'd5, 20'hD, 1'b0, mkExp("touchD", 1, 2'd3, 1, 1, 1, DIRTY_ON, 20'hA));
      lookup(6'd5, 20'h77, 1'b0, mkExp("dirtyVic", 0, 2'd0, 1, 1, 1, DIRTY_ON, 20'hA));

      expQ.push_back(mkExp("sameCycle", 0, 2'd0, 1, 1, 1, DIRTY_ON, 20'hA));
      applyStimulus(1'b1, 6'd5, 20'hE, 1'b0, 1'b1, 6'd5, 2'd3, 20'hE, 1'b0, 1'b0);
      lookup(6'd5, 20'hE, 1'b0, mkExp("afterFill", 1, 2'd3, 1, 1, 1, DIRTY_ON, 20'hA));

      fill(6'd7, 2'd0, 20'h55, 1'b1);
      lookup(6'd7, 20'h66, 1'b0, mkExp("partialMiss", 0, 2'd1, 1, 0, 1, 0, 20'h0));
      lookup(6'd7, 20'h55, 1'b0, mkExp("partialHit", 1, 2'd0, 1, 0, 1, 0, 20'h0));
      lookup(6'd6, 20'hA, 1'b0, mkExp("otherSet", 0, 2'd0, 1, 0, 1, 0, 20'h0));

      // Full flush with a lookup, a fill and a repeated flush_req injected while busy
      applyStimulus(1'b0, 6'd0, 20'd0, 1'b0, 1'b0, 6'd0, 2'd0, 20'd0, 1'b0, 1'b1);
      busyCycles = 0;
      doneCount  = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         busyCycles++;
         if (flush_done) doneCount++;
         lk_valid  = (i == 3);
         upd_en    = (i == 20);
         flush_req = (i == 10);
         if (i == 3) begin
            lk_index = 6'd5; lk_tag = 20'hB;
            expQ.push_back(mkExp("busyLookup", 0, 2'd0, 0, 0, 0, 0, 20'h0));
         end
         if (i == 20) begin
            upd_index = 6'd9; upd_way = 2'd0; upd_tag = 20'h99; upd_dirty = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      lk_valid = 0; upd_en = 0; flush_req = 0;
      checkOutput("flush_busyCycles", 32'(busyCycles), 32'd65);
      checkOutput("flush_donePulses", 32'(doneCount), 32'd1);
      checkOutput("flush_doneLow", 32'(flush_done), 0);
      lookup(6'd5, 20'hB, 1'b0, mkExp("postFlush5", 0, 2'd0, 1, 0, 1, 0, 20'hA));
      lookup(6'd7, 20'h55, 1'b0, mkExp("postFlush7", 0, 2'd0, 1, 0, 0, 0, 20'h0));
      lookup(6'd9, 20'h99, 1'b0, mkExp("busyFillIgnored", 0, 2'd0, 1, 0, 0, 0, 20'h0));

      // Reset in the middle of a flush aborts it without a done pulse
      fill(6'd3, 2'd1, 20'h33, 1'b0);
      lookup(6'd3, 20'h33, 1'b0, mkExp("preReset", 1, 2'd1, 1, 0, 1, 0, 20'h0));
      applyStimulus(1'b0, 6'd0, 20'd0, 1'b0, 1'b0, 6'd0, 2'd0, 20'd0, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("midFlush_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_flushDone", 32'(flush_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      doneCount  = 0;
      busyCycles = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (flush_done) doneCount++;
         if (busy) busyCycles++;
      end
      checkOutput("abort_noDone", 32'(doneCount), 0);
      checkOutput("abort_noBusy", 32'(busyCycles), 0);
      lookup(6'd3, 20'h33, 1'b0, mkExp("postReset3", 0, 2'd0, 1, 0, 1, 0, 20'h0));
      lookup(6'd5, 20'hE, 1'b0, mkExp("postReset5", 0, 2'd0, 1, 0, 1, 0, 20'h0));

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboardDrained", 32'(expQ.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
